mor1kx_wb_arbiter: RTL and testbench
====================================

// Module: mor1kx_wb_arbiter
// PURPOSE
// Shares one Wishbone B3 slave port (mor1kx_mem_model) between the mor1kx instruction (iwb) and
// data (dwb) masters. Grants one master at a time and holds the grant for its whole cycle,
// including bursts. A watchdog ends hung transfers with err. Sits between core and memory model.
// PARAMETERS
// AW       32   address width
// DW       32   data width (DW/8 byte selects)
// TIMEOUT  255  granted stb cycles with no ack/err/rty before a forced err; 0 disables watchdog
// PRIO_D   1    tie winner of first arbitration after reset: 1 = dwb, 0 = iwb
// PORTS
// clk                               input   1     clock
// rst_n                             input   1     synchronous reset, active-low
// {i,d}wb_cyc_i/stb_i/we_i          input   1     master cycle / strobe / write enable
// {i,d}wb_adr_i                     input   AW    master address
// {i,d}wb_sel_i                     input   DW/8  master byte selects
// {i,d}wb_cti_i                     input   3     master cycle type
// {i,d}wb_bte_i                     input   2     master burst type
// {i,d}wb_dat_i                     input   DW    master write data
// {i,d}wb_dat_o                     output  DW    read data to master (= wbs_dat_i)
// {i,d}wb_ack_o/err_o/rty_o         output  1     termination to master
// wbs_cyc_o/stb_o/we_o              output  1     slave cycle / strobe / write enable
// wbs_adr_o / wbs_sel_o             output  AW / DW/8  slave address / byte selects
// wbs_cti_o / wbs_bte_o             output  3 / 2      slave cycle type / burst type
// wbs_dat_o                         output  DW    slave write data
// wbs_dat_i                         input   DW    slave read data
// wbs_ack_i/err_i/rty_i             input   1     slave termination
// grant_o                           output  2     one-hot owner {dwb,iwb}; 00 = idle
// timeout_o                         output  1     one-cycle pulse on a forced err
// BEHAVIOUR
// - State register is IDLE/OWN_I/OWN_D. Registered last_owner bit. Watchdog counter is
//   $clog2(TIMEOUT+1) bits wide.
// - Reset (rst_n low at posedge): state IDLE, last_owner = PRIO_D ? I : D, counter 0.
//   All wbs_* outputs, ack/err/rty, grant_o and timeout_o are 0 from the next cycle.
// - wbs_* outputs are a combinational mux of the owner's signals, gated by state.
//   All are 0 in IDLE.
// - Owner ack/err/rty = slave ack/err/rty. Non-owner ack/err/rty are held at 0.
//   dat_o is ungated: both masters see wbs_dat_i and qualify it with ack.
// - Arbitration: evaluated in IDLE, and in OWN_x in the cycle the owner's cyc is low.
//   - Exactly one cyc high: that master is granted.
//   - Both high: the master != last_owner is granted (round robin).
//   - None high: go to IDLE.
// - The grant is registered. The slave sees cyc/stb one cycle after the master raises cyc,
//   so arbitration latency is 1 cycle.
// - Handoff is direct: OWN_I -> OWN_D with no idle cycle when iwb drops cyc while dwb
//   requests. last_owner updates on every entry to OWN_x.
// - The grant is held while the owner's cyc is high, regardless of cti/bte.
//   Incrementing bursts (cti=010) and classic cycles pass through unchanged.
// - Non-owner requests are stalled (no termination) until granted; never dropped or errored.
// - Owner drops cyc while the slave is still busy: the grant is released.
//   A late slave ack/err/rty after release is discarded, not routed.
// - Watchdog counting:
//   - Increments each OWN_x cycle with owner stb high and no slave ack/err/rty.
//   - Clears on any slave termination, on stb low, and on any state change.
// - Watchdog expiry (TIMEOUT != 0, counter == TIMEOUT, still no slave termination):
//   - owner err_o = 1 for that single cycle; wbs_stb_o is forced 0 that cycle.
//   - timeout_o = 1 that cycle; counter clears.
//   - The grant stays held; the owner decides whether to drop cyc.
// - Simultaneous slave termination and expiry: the slave termination wins, with no forced err
//   and no timeout_o.
// - TIMEOUT = 0: the counter is held at 0 and timeout_o stays 0.
// TESTING
// - iwb-only read at adr 0x100; slave acks 2 cycles after stb with 0xDEADBEEF
//   -> wbs_cyc_o rises 1 cycle after iwb_cyc_i, grant_o = 01, iwb_ack_o = 1 with dat 0xDEADBEEF,
//   dwb_ack_o = 0.
// - After reset, both cyc rise in the same cycle with PRIO_D = 1
//   -> grant_o = 10 first; dwb drops cyc -> grant_o = 01 the next cycle, no idle gap.
//   Repeat the tie -> dwb wins.
// - iwb 4-beat burst (cti 010,010,010,111) while dwb requests
//   -> 4 acks to iwb, zero acks to dwb until iwb cyc falls, then dwb is granted.
// - TIMEOUT = 8, dwb write, slave never responds
//   -> dwb_err_o and timeout_o pulse for exactly 1 cycle, 8 stb cycles after grant.
//   wbs_stb_o = 0 in that cycle.
// - rst_n low mid-burst with grant_o = 01
//   -> next cycle grant_o = 00, wbs_cyc_o = 0, a subsequent slave ack is not routed to iwb.
// - TIMEOUT = 8, slave ack in the same cycle the counter reaches 8
//   -> ack delivered to owner, err_o = 0, timeout_o = 0.

Source files
------------

// File: rtl/mor1kx_wb_arbiter.sv
// rtl/mor1kx_wb_arbiter.sv - two-master Wishbone B3 arbiter (iwb/dwb) with hung-transfer watchdog
module mor1kx_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int PRIO_D  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iwb_cyc_i,
  input  logic            iwb_stb_i,
  input  logic            iwb_we_i,
  input  logic [AW-1:0]   iwb_adr_i,
  input  logic [DW/8-1:0] iwb_sel_i,
  input  logic [2:0]      iwb_cti_i,
  input  logic [1:0]      iwb_bte_i,
  input  logic [DW-1:0]   iwb_dat_i,
  output logic [DW-1:0]   iwb_dat_o,
  output logic            iwb_ack_o,
  output logic            iwb_err_o,
  output logic            iwb_rty_o,
  input  logic            dwb_cyc_i,
  input  logic            dwb_stb_i,
  input  logic            dwb_we_i,
  input  logic [AW-1:0]   dwb_adr_i,
  input  logic [DW/8-1:0] dwb_sel_i,
  input  logic [2:0]      dwb_cti_i,
  input  logic [1:0]      dwb_bte_i,
  input  logic [DW-1:0]   dwb_dat_i,
  output logic [DW-1:0]   dwb_dat_o,
  output logic            dwb_ack_o,
  output logic            dwb_err_o,
  output logic            dwb_rty_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic            wbs_we_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [DW/8-1:0] wbs_sel_o,
  output logic [2:0]      wbs_cti_o,
  output logic [1:0]      wbs_bte_o,
  output logic [DW-1:0]   wbs_dat_o,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i,
  input  logic            wbs_rty_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  // A zero TIMEOUT would give a zero-width counter; keep one bit and hold it at 0.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          last_d, last_d_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          own_i, own_d;
  logic          owner_cyc, owner_stb;
  logic          slave_term;
  logic          expire;

  assign own_i      = (state == OWN_I);
  assign own_d      = (state == OWN_D);
  assign slave_term = wbs_ack_i | wbs_err_i | wbs_rty_i;

  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_adr_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbs_dat_o = '0;
    case (state)
      OWN_I: begin
        owner_cyc = iwb_cyc_i;
        owner_stb = iwb_stb_i;
        wbs_we_o  = iwb_we_i;
        wbs_adr_o = iwb_adr_i;
        wbs_sel_o = iwb_sel_i;
        wbs_cti_o = iwb_cti_i;
        wbs_bte_o = iwb_bte_i;
        wbs_dat_o = iwb_dat_i;
      end
      OWN_D: begin
        owner_cyc = dwb_cyc_i;
        owner_stb = dwb_stb_i;
        wbs_we_o  = dwb_we_i;
        wbs_adr_o = dwb_adr_i;
        wbs_sel_o = dwb_sel_i;
        wbs_cti_o = dwb_cti_i;
        wbs_bte_o = dwb_bte_i;
        wbs_dat_o = dwb_dat_i;
      end
      default: ;
    endcase
  end

  // A slave termination in the expiry cycle wins over the forced err.
  assign expire = (TIMEOUT != 0) && (own_i || own_d) && owner_cyc && owner_stb &&
                  !slave_term && (cnt == CW'(TIMEOUT));

  always_comb begin
    state_nx  = state;
    last_d_nx = last_d;
    cnt_nx    = '0;
    if (!owner_cyc) begin
      if (iwb_cyc_i && dwb_cyc_i) state_nx = last_d ? OWN_I : OWN_D;
      else if (iwb_cyc_i)         state_nx = OWN_I;
      else if (dwb_cyc_i)         state_nx = OWN_D;
      else                        state_nx = IDLE;
    end
    if (state_nx == OWN_D)      last_d_nx = 1'b1;
    else if (state_nx == OWN_I) last_d_nx = 1'b0;
    if ((TIMEOUT != 0) && (state_nx == state) && (state != IDLE) &&
        owner_stb && !slave_term && !expire)
      cnt_nx = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_d <= (PRIO_D == 0);
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      last_d <= last_d_nx;
      cnt    <= cnt_nx;
    end
  end

  assign wbs_cyc_o = owner_cyc;
  assign wbs_stb_o = owner_stb & ~expire;

  assign iwb_dat_o = wbs_dat_i;
  assign dwb_dat_o = wbs_dat_i;
  assign iwb_ack_o = own_i & wbs_ack_i;
  assign iwb_err_o = own_i & (wbs_err_i | expire);
  assign iwb_rty_o = own_i & wbs_rty_i;
  assign dwb_ack_o = own_d & wbs_ack_i;
  assign dwb_err_o = own_d & (wbs_err_i | expire);
  assign dwb_rty_o = own_d & wbs_rty_i;

  assign grant_o   = {own_d, own_i};
  assign timeout_o = expire;

endmodule

// File: tb/tb_mor1kx_wb_arbiter.sv
// tb/tb_mor1kx_wb_arbiter.sv - vector, corner-case and randomized checks for mor1kx_wb_arbiter
module tb_mor1kx_wb_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       m_cyc, m_stb, m_we;
  logic [1:0][31:0] m_adr, m_dat;
  logic [1:0][3:0]  m_sel;
  logic [1:0][2:0]  m_cti;
  logic [1:0][1:0]  m_bte;
  logic [31:0]      idat_o, ddat_o, wbs_adr_o, wbs_dat_o, s_dat;
  logic             iack, ierr, irty, dack, derr, drty;
  logic             wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [3:0]       wbs_sel_o;
  logic [2:0]       wbs_cti_o;
  logic [1:0]       wbs_bte_o;
  logic             s_ack, s_err, s_rty;
  logic [1:0]       grant_o;
  logic             timeout_o;

  int checks = 0;
  int failures = 0;

  mor1kx_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO), .PRIO_D(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .iwb_cyc_i(m_cyc[0]), .iwb_stb_i(m_stb[0]), .iwb_we_i(m_we[0]), .iwb_adr_i(m_adr[0]),
    .iwb_sel_i(m_sel[0]), .iwb_cti_i(m_cti[0]), .iwb_bte_i(m_bte[0]), .iwb_dat_i(m_dat[0]),
    .iwb_dat_o(idat_o), .iwb_ack_o(iack), .iwb_err_o(ierr), .iwb_rty_o(irty),
    .dwb_cyc_i(m_cyc[1]), .dwb_stb_i(m_stb[1]), .dwb_we_i(m_we[1]), .dwb_adr_i(m_adr[1]),
    .dwb_sel_i(m_sel[1]), .dwb_cti_i(m_cti[1]), .dwb_bte_i(m_bte[1]), .dwb_dat_i(m_dat[1]),
    .dwb_dat_o(ddat_o), .dwb_ack_o(dack), .dwb_err_o(derr), .dwb_rty_o(drty),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o), .wbs_adr_o(wbs_adr_o),
    .wbs_sel_o(wbs_sel_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_dat_o(wbs_dat_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    bit rst, ic, is, dc, ds, ack, err;
    bit [1:0] g;
    bit ia, da, ie, de, to, sc, ss;
  } vec_t;

  function automatic vec_t v(bit rst, bit ic, bit is, bit dc, bit ds, bit ack, bit err,
                             bit [1:0] g, bit ia, bit da, bit ie, bit de, bit to, bit sc, bit ss);
    v = '{rst, ic, is, dc, ds, ack, err, g, ia, da, ie, de, to, sc, ss};
  endfunction

  task automatic set_idle();
    rst_n = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = 2'b10;
    m_adr[0] = 32'h100; m_adr[1] = 32'h200;
    m_dat[0] = 32'hCAFE0001; m_dat[1] = 32'hCAFE0002;
    m_sel = '1; m_cti = '0; m_bte = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    s_dat = 32'hDEADBEEF;
  endtask

  logic [8:0] obs9;
  assign obs9 = {grant_o, iack, dack, ierr, derr, timeout_o, wbs_cyc_o, wbs_stb_o};

  // Reference model: owner index (-1 none, 0 iwb, 1 dwb), last granted index,
  // and the number of consecutive unanswered strobes of the current owner.
  int own, last, stall;
  bit e_exp;
  logic [20:0]  e_ctrl;
  logic [127:0] e_bus;

  task automatic model_eval();
    bit term, oc, os;
    term = s_ack | s_err | s_rty;
    oc = 1'b0; os = 1'b0; e_exp = 1'b0;
    e_ctrl = '0;
    e_bus = {64'h0, s_dat, s_dat};
    if (own >= 0) begin
      oc = m_cyc[own];
      os = m_stb[own];
      e_exp = oc && os && !term && (stall == TO);
      e_ctrl = {own == 1, own == 0, e_exp,
                own == 0 && s_ack, own == 0 && (s_err || e_exp), own == 0 && s_rty,
                own == 1 && s_ack, own == 1 && (s_err || e_exp), own == 1 && s_rty,
                oc, os && !e_exp, m_we[own], m_cti[own], m_bte[own], m_sel[own]};
      e_bus = {m_adr[own], m_dat[own], s_dat, s_dat};
    end
  endtask

  task automatic model_step();
    int nxt;
    bit term;
    term = s_ack | s_err | s_rty;
    if (!rst_n) begin
      own = -1; last = 0; stall = 0;
      return;
    end
    if (own >= 0 && m_cyc[own]) nxt = own;
    else if (m_cyc[0] && m_cyc[1]) nxt = 1 - last;
    else if (m_cyc[0]) nxt = 0;
    else if (m_cyc[1]) nxt = 1;
    else nxt = -1;
    if (nxt != own || own < 0 || e_exp || !m_stb[own] || term) stall = 0;
    else stall++;
    if (nxt >= 0) last = nxt;
    own = nxt;
  endtask

  vec_t tv[$];
  logic [2:0] bcti [4];
  int ack_i_cnt, ack_d_cnt, pulses;

  initial begin
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //              rst ic is dc ds ak er   g    ia da ie de to sc ss
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(v(1, 1, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(v(1, 1, 1, 0, 0, 1, 0, 2'b01, 1, 0, 0, 0, 0, 1, 1));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 1, 1, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(v(1, 1, 1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 1, 1, 1, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(v(1, 1, 1, 1, 1, 1, 0, 2'b10, 0, 1, 0, 0, 0, 1, 1));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 1, 1, 0, 1, 2'b10, 0, 0, 0, 1, 0, 1, 1));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    foreach (tv[i]) begin
      rst_n = tv[i].rst;
      m_cyc = {tv[i].dc, tv[i].ic};
      m_stb = {tv[i].ds, tv[i].is};
      s_ack = tv[i].ack;
      s_err = tv[i].err;
      #1;
      chk($sformatf("vec%0d", i), obs9,
          {tv[i].g, tv[i].ia, tv[i].da, tv[i].ie, tv[i].de, tv[i].to, tv[i].sc, tv[i].ss});
      if (tv[i].ia) chk($sformatf("vec%0d_dat", i), idat_o, 32'hDEADBEEF);
      if (tv[i].sc) chk($sformatf("vec%0d_adr", i), wbs_adr_o, tv[i].g[1] ? 32'h200 : 32'h100);
      @(negedge clk);
    end

    // iwb 4-beat burst while dwb waits; last owner is dwb so the tie goes to iwb.
    set_idle();
    bcti[0] = 3'b010; bcti[1] = 3'b010; bcti[2] = 3'b010; bcti[3] = 3'b111;
    ack_i_cnt = 0; ack_d_cnt = 0;
    m_cyc = 2'b11; m_stb = 2'b11; m_cti[0] = 3'b010;
    for (int k = 0; k < 8; k++) begin
      if (k >= 1 && k <= 4) begin
        m_cti[0] = bcti[k-1];
        m_adr[0] = 32'h100 + 32'(4 * (k - 1));
        s_ack = 1'b1;
      end else s_ack = 1'b0;
      if (k == 5) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      if (k == 7) begin m_cyc[1] = 1'b0; m_stb[1] = 1'b0; end
      #1;
      ack_i_cnt += int'(iack);
      if (k <= 5) ack_d_cnt += int'(dack);
      if (k >= 1 && k <= 4) chk($sformatf("burst_cti%0d", k), wbs_cti_o, bcti[k-1]);
      if (k == 0) chk("burst_g0", grant_o, 2'b00);
      if (k == 5) chk("burst_hold", grant_o, 2'b01);
      if (k == 6) chk("burst_handoff", {grant_o, wbs_cyc_o}, 3'b101);
      @(negedge clk);
    end
    chk("burst_iacks", ack_i_cnt, 4);
    chk("burst_dacks", ack_d_cnt, 0);
    @(negedge clk);

    // Watchdog expiry on a dwb write that the slave never answers.
    set_idle();
    pulses = 0;
    m_cyc = 2'b10; m_stb = 2'b10;
    for (int k = 0; k <= 12; k++) begin
      #1;
      if (k == 0) chk("wd_g0", grant_o, 2'b00);
      else chk($sformatf("wd_c%0d", k), {grant_o, derr, timeout_o, wbs_stb_o},
               {2'b10, k == 9, k == 9, k != 9});
      pulses += int'(timeout_o);
      @(negedge clk);
    end
    chk("wd_pulses", pulses, 1);
    m_cyc = '0; m_stb = '0;
    @(negedge clk);
    @(negedge clk);

    // Slave ack lands in the very cycle the counter reaches the limit.
    m_cyc = 2'b10; m_stb = 2'b10;
    for (int k = 0; k <= 10; k++) begin
      s_ack = (k == 9);
      #1;
      if (k == 9) chk("race_ack", {dack, derr, timeout_o, wbs_stb_o}, 4'b1001);
      if (k == 10) chk("race_after", {dack, derr, timeout_o}, 3'b000);
      @(negedge clk);
    end
    set_idle();
    @(negedge clk);
    @(negedge clk);

    // Reset while iwb owns the bus; the following slave ack must not reach iwb.
    m_cyc = 2'b01; m_stb = 2'b01;
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("rst_pre", {grant_o, iack}, 3'b011);
    @(negedge clk);
    s_ack = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_cycle", grant_o, 2'b01);
    @(negedge clk);
    rst_n = 1'b1; s_ack = 1'b1;
    #1;
    chk("rst_after", {grant_o, wbs_cyc_o, iack}, 4'b0000);
    @(negedge clk);
    s_ack = 1'b0;
    #1;
    chk("rst_regrant", grant_o, 2'b01);
    @(negedge clk);

    // Randomized traffic against the reference model.
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    own = -1; last = 0; stall = 0;
    for (int n = 0; n < 3000; n++) begin
      bit quiet;
      quiet = ((n / 64) % 3) == 2;
      for (int m = 0; m < 2; m++) begin
        if (m_cyc[m] && $urandom_range(7) == 0) m_cyc[m] = 1'b0;
        else if (!m_cyc[m] && $urandom_range(3) == 0) m_cyc[m] = 1'b1;
        m_stb[m] = m_cyc[m] && ($urandom_range(7) != 0);
        m_we[m]  = 1'($urandom);
        m_adr[m] = $urandom;
        m_dat[m] = $urandom;
        m_sel[m] = 4'($urandom);
        m_cti[m] = 3'($urandom);
        m_bte[m] = 2'($urandom);
      end
      s_ack = !quiet && ($urandom_range(3) == 0);
      s_err = !quiet && ($urandom_range(15) == 0);
      s_rty = !quiet && ($urandom_range(15) == 0);
      s_dat = $urandom;
      rst_n = ($urandom_range(299) != 0);
      #1;
      model_eval();
      chk("rand_ctrl", {grant_o, timeout_o, iack, ierr, irty, dack, derr, drty,
                        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_sel_o}, e_ctrl);
      chk("rand_bus", {wbs_adr_o, wbs_dat_o, idat_o, ddat_o}, e_bus);
      model_step();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
